// File: rtl/gb_apu_pkg.sv
// Shared constants and CPU request bundle for the APU wave RAM and its
// access-window logic.
package gb_apu_pkg;

  localparam int         WAVE_RAM_DEPTH  = 16;
  localparam int         WAVE_AW         = $clog2(WAVE_RAM_DEPTH);
  localparam int         WAVE_WIN_CYCLES = 2;
  localparam logic [7:0] WAVE_OPEN_BUS   = 8'hFF;

  typedef struct packed {
    logic               wr;
    logic               rd;
    logic [WAVE_AW-1:0] addr;
    logic [7:0]         wdata;
  } wave_cpu_req_t;

endpackage

// File: rtl/gb_apu_wave_window.sv
// Tracks wave-channel byte fetches and keeps a short window open after each
// one, during which the CPU may touch wave RAM while the channel plays.
module gb_apu_wave_window
  import gb_apu_pkg::*;
#(
  parameter int WIN_CYCLES = WAVE_WIN_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ch_enable,
  input  logic [WAVE_AW-1:0] ch_addr,
  output logic               fetch,
  output logic               access_ok
);

  localparam int            CW   = (WIN_CYCLES < 2) ? 1 : $clog2(WIN_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(WIN_CYCLES - 1);

  logic [WAVE_AW-1:0] ch_addr_q;
  logic               ch_enable_q;
  logic [CW-1:0]      cnt;

  // A fresh enable counts as a fetch, as does any address change (wrap included).
  assign fetch     = ch_enable && ((ch_addr != ch_addr_q) || !ch_enable_q);
  assign access_ok = fetch || (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_addr_q   <= '0;
      ch_enable_q <= 1'b0;
      cnt         <= '0;
    end else begin
      ch_addr_q   <= ch_addr;
      ch_enable_q <= ch_enable;
      if (fetch)
        cnt <= LOAD;
      else if (!ch_enable)
        cnt <= '0;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/gb_apu_wave_ram.sv
// 16-byte wave RAM shared between the CPU and the custom wave channel.
// While the channel plays, CPU accesses are redirected to the byte being played.
module gb_apu_wave_ram
  import gb_apu_pkg::*;
#(
  parameter int WIN_CYCLES = WAVE_WIN_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WAVE_AW-1:0] cpu_addr,
  input  logic               cpu_wr,
  input  logic               cpu_rd,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  input  logic               ch_enable,
  input  logic [WAVE_AW-1:0] ch_addr,
  output logic [7:0]         ch_data
);

  logic [WAVE_RAM_DEPTH-1:0][7:0] mem;
  wave_cpu_req_t                  req;
  logic                           fetch;
  logic                           access_ok;
  logic                           allowed;
  logic [WAVE_AW-1:0]             eff_addr;

  assign req = '{wr: cpu_wr, rd: cpu_rd, addr: cpu_addr, wdata: cpu_wdata};

  gb_apu_wave_window #(.WIN_CYCLES(WIN_CYCLES)) u_window (
    .clk       (clk),
    .reset     (reset),
    .ch_enable (ch_enable),
    .ch_addr   (ch_addr),
    .fetch     (fetch),
    .access_ok (access_ok)
  );

  assign ch_data  = mem[ch_addr];
  assign allowed  = !ch_enable || access_ok;
  assign eff_addr = ch_enable ? ch_addr : req.addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem       <= '0;
      cpu_rdata <= 8'h00;
    end else begin
      if (req.wr) begin
        if (allowed)
          mem[eff_addr] <= req.wdata;
      end else if (req.rd) begin
        // Outside the window the CPU sees an undriven bus.
        cpu_rdata <= allowed ? mem[eff_addr] : WAVE_OPEN_BUS;
      end
    end
  end

endmodule
